// File: rtl/plane_mover.sv
// plane_mover
//   Turns held direction requests from the button encoder into the player
//   plane's on-screen position. The position moves by STEP pixels on frame
//   ticks: once on the first tick after a press, again after HOLD_FRAMES
//   ticks, then every REPEAT_FRAMES ticks while the same direction is held.
//   Steps are clamped at the playfield limits. The game controller can
//   freeze movement or respawn the plane at its initial position.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   frame_tick_i  one-cycle pulse per video frame
//   move_en_i     direction request valid
//   direct_i      direction code (`UP, `DOWN, `LEFT, `RIGHT)
//   freeze_i      pause / game over: movement suppressed while high
//   respawn_i     one-cycle pulse: reload the initial position
//   pos_x_o       plane x (registered)
//   pos_y_o       plane y (registered)
//   moving_o      high while a press is active (PRESS, HOLD or REPEAT)
//   edge_hit_o    one-cycle pulse, aligned with the position update, when a
//                 step hit a limit
//
// Build option
//   PLANE_MOVER_WRAP_X_EN : when defined, horizontal steps that cross a limit
//                           wrap to the opposite limit instead of clamping.
//                           The vertical axis always clamps.

`ifndef UP
`define UP    2'b00
`endif
`ifndef DOWN
`define DOWN  2'b01
`endif
`ifndef LEFT
`define LEFT  2'b10
`endif
`ifndef RIGHT
`define RIGHT 2'b11
`endif

module plane_mover #(
    parameter int POS_W         = 10,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 600,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 440,
    parameter int X_INIT        = 300,
    parameter int Y_INIT        = 400,
    parameter int STEP          = 4,
    parameter int HOLD_FRAMES   = 8,
    parameter int REPEAT_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick_i,
    input  logic             move_en_i,
    input  logic [1:0]       direct_i,
    input  logic             freeze_i,
    input  logic             respawn_i,
    output logic [POS_W-1:0] pos_x_o,
    output logic [POS_W-1:0] pos_y_o,
    output logic             moving_o,
    output logic             edge_hit_o
);

    localparam int CNT_MAX = (HOLD_FRAMES > REPEAT_FRAMES) ? HOLD_FRAMES : REPEAT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_FRAMES - 1);

    // Step arithmetic runs one bit wider than the position so that neither
    // y+STEP nor y-STEP can wrap before the limit comparison.
    localparam logic [POS_W:0]   STEP_W = (POS_W + 1)'(STEP);

    localparam logic [POS_W-1:0] X_MIN_P  = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] X_MAX_P  = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_MIN_P  = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] Y_MAX_P  = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] X_INIT_P = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] Y_INIT_P = POS_W'(Y_INIT);

`ifdef PLANE_MOVER_WRAP_X_EN
    localparam logic WRAP_X = 1'b1;
`else
    localparam logic WRAP_X = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_HOLD,
        S_REPEAT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       dir_q,   dir_d;
    logic [POS_W-1:0] x_q,     x_d;
    logic [POS_W-1:0] y_q,     y_d;
    logic             moving_q, moving_d;
    logic             hit_q,   hit_d;

    logic             do_step;
    logic [POS_W:0]   step_x;
    logic [POS_W:0]   step_y;

    // Returns {hit, new_pos}. A step that would cross a limit lands on that
    // limit (or on the opposite one when wrapping) and reports hit, even if
    // the position was already sitting on the limit.
    function automatic logic [POS_W:0] step_axis(
        input logic [POS_W-1:0] pos,
        input logic             dec,
        input logic             wrap,
        input logic [POS_W-1:0] lo,
        input logic [POS_W-1:0] hi
    );
        logic [POS_W:0]   p;
        logic [POS_W-1:0] nxt;
        logic             hit;
        p   = {1'b0, pos};
        hit = 1'b0;
        if (dec) begin
            if (p < ({1'b0, lo} + STEP_W)) begin
                hit = 1'b1;
                nxt = wrap ? hi : lo;
            end else begin
                nxt = POS_W'(p - STEP_W);
            end
        end else begin
            if ((p + STEP_W) > {1'b0, hi}) begin
                hit = 1'b1;
                nxt = wrap ? lo : hi;
            end else begin
                nxt = POS_W'(p + STEP_W);
            end
        end
        return {hit, nxt};
    endfunction

    assign step_x = step_axis(x_q, (dir_q == `LEFT), WRAP_X, X_MIN_P, X_MAX_P);
    assign step_y = step_axis(y_q, (dir_q == `UP),   1'b0,   Y_MIN_P, Y_MAX_P);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        hit_d   = 1'b0;
        do_step = 1'b0;

        if (respawn_i) begin
            x_d     = X_INIT_P;
            y_d     = Y_INIT_P;
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (freeze_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A tick arriving together with the press is ignored;
                    // the first step waits for the next tick.
                    if (move_en_i) begin
                        dir_d   = direct_i;
                        state_d = S_PRESS;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    if (!move_en_i) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (direct_i != dir_q) begin
                        // New direction behaves like a fresh press.
                        dir_d   = direct_i;
                        state_d = S_PRESS;
                        cnt_d   = '0;
                    end else if (frame_tick_i) begin
                        case (state_q)
                            S_PRESS: begin
                                do_step = 1'b1;
                                cnt_d   = '0;
                                state_d = S_HOLD;
                            end
                            S_HOLD: begin
                                if (cnt_q == HOLD_LAST) begin
                                    do_step = 1'b1;
                                    cnt_d   = '0;
                                    state_d = S_REPEAT;
                                end else begin
                                    cnt_d = cnt_q + CNT_W'(1);
                                end
                            end
                            default: begin
                                if (cnt_q == REPEAT_LAST) begin
                                    do_step = 1'b1;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + CNT_W'(1);
                                end
                            end
                        endcase
                    end
                end
            endcase
        end

        if (do_step) begin
            if ((dir_q == `LEFT) || (dir_q == `RIGHT)) begin
                x_d   = step_x[POS_W-1:0];
                hit_d = step_x[POS_W];
            end else begin
                y_d   = step_y[POS_W-1:0];
                hit_d = step_y[POS_W];
            end
        end

        moving_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dir_q    <= `DOWN;
            x_q      <= X_INIT_P;
            y_q      <= Y_INIT_P;
            moving_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
            moving_q <= moving_d;
            hit_q    <= hit_d;
        end
    end

    assign pos_x_o    = x_q;
    assign pos_y_o    = y_q;
    assign moving_o   = moving_q;
    assign edge_hit_o = hit_q;

endmodule

// File: tb/tb_plane_mover.sv
// Self-checking bench for plane_mover: a directed vector table, hand-written
// multi-cycle sequences (long hold, direction change in repeat, edge clamp)
// and a randomized run compared against a tick-counting reference model.

`ifndef UP
`define UP    2'b00
`endif
`ifndef DOWN
`define DOWN  2'b01
`endif
`ifndef LEFT
`define LEFT  2'b10
`endif
`ifndef RIGHT
`define RIGHT 2'b11
`endif

module tb_plane_mover;

    localparam int POS_W = 10;
    localparam int X_MIN = 0,  X_MAX = 600;
    localparam int Y_MIN = 0,  Y_MAX = 440;
    localparam int X_INIT = 300, Y_INIT = 400;
    localparam int STEP = 4, HOLD_FRAMES = 8, REPEAT_FRAMES = 2;
`ifdef PLANE_MOVER_WRAP_X_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_tick_i = 1'b0;
    logic             move_en_i = 1'b0;
    logic [1:0]       direct_i = `DOWN;
    logic             freeze_i = 1'b0;
    logic             respawn_i = 1'b0;
    logic [POS_W-1:0] pos_x_o, pos_y_o;
    logic             moving_o, edge_hit_o;

    plane_mover dut (
        .clk(clk), .rst(rst), .frame_tick_i(frame_tick_i), .move_en_i(move_en_i),
        .direct_i(direct_i), .freeze_i(freeze_i), .respawn_i(respawn_i),
        .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .moving_o(moving_o), .edge_hit_o(edge_hit_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts ticks since the current press began and steps
    // on tick 1, tick 1+HOLD_FRAMES, then every REPEAT_FRAMES ticks.
    int         mx, my, mn;
    bit         mact, mmov, mhit;
    logic [1:0] mdir;

    function automatic bit is_step_tick(input int n);
        if (n == 1) return 1'b1;
        if (n < 1 + HOLD_FRAMES) return 1'b0;
        return ((n - 1 - HOLD_FRAMES) % REPEAT_FRAMES) == 0;
    endfunction

    task automatic model_move(input logic [1:0] d);
        case (d)
            `UP:    if (my - STEP < Y_MIN) begin my = Y_MIN; mhit = 1; end else my = my - STEP;
            `DOWN:  if (my + STEP > Y_MAX) begin my = Y_MAX; mhit = 1; end else my = my + STEP;
            `LEFT:  if (mx - STEP < X_MIN) begin mx = WRAP ? X_MAX : X_MIN; mhit = 1; end
                    else mx = mx - STEP;
            default: if (mx + STEP > X_MAX) begin mx = WRAP ? X_MIN : X_MAX; mhit = 1; end
                    else mx = mx + STEP;
        endcase
    endtask

    task automatic model_update(input bit t, input bit en, input logic [1:0] d,
                                input bit f, input bit r, input bit rs);
        mhit = 0;
        if (rs) begin
            mx = X_INIT; my = Y_INIT; mact = 0; mdir = `DOWN; mn = 0;
        end else if (r) begin
            mx = X_INIT; my = Y_INIT; mact = 0;
        end else if (f) begin
            mact = 0;
        end else if (!mact) begin
            if (en) begin mact = 1; mdir = d; mn = 0; end
        end else if (!en) begin
            mact = 0;
        end else if (d != mdir) begin
            mdir = d; mn = 0;
        end else if (t) begin
            mn++;
            if (is_step_tick(mn)) model_move(mdir);
        end
        mmov = mact;
    endtask

    // One clock cycle: drive inputs, clock edge, advance model, sample #1 later.
    task automatic cyc(input bit t, input bit en, input logic [1:0] d,
                       input bit f, input bit r, input bit rs);
        frame_tick_i = t; move_en_i = en; direct_i = d;
        freeze_i = f; respawn_i = r; rst = rs;
        @(posedge clk);
        model_update(t, en, d, f, r, rs);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        cyc(0, 0, `DOWN, 0, 0, 1);
        cyc(0, 0, `DOWN, 0, 0, 1);
    endtask

    typedef struct {
        bit         t;
        bit         en;
        logic [1:0] d;
        bit         f;
        bit         r;
        int         ex;
        int         ey;
        bit         em;
        bit         eh;
    } vec_t;

    vec_t vt[16];

    initial begin : main
        int steps_seen;
        int ey;
        bit reached;
        bit stepped;

        vt[0]  = '{0, 1, `RIGHT, 0, 0, 300, 400, 1, 0};  // press, no step yet
        vt[1]  = '{1, 1, `RIGHT, 0, 0, 304, 400, 1, 0};  // first tick steps
        vt[2]  = '{0, 1, `RIGHT, 0, 0, 304, 400, 1, 0};
        vt[3]  = '{1, 1, `RIGHT, 0, 0, 304, 400, 1, 0};  // counts only in HOLD
        vt[4]  = '{0, 0, `RIGHT, 0, 0, 304, 400, 0, 0};  // release
        vt[5]  = '{1, 0, `RIGHT, 0, 0, 304, 400, 0, 0};
        vt[6]  = '{1, 1, `LEFT,  0, 0, 304, 400, 1, 0};  // tick with press: no step
        vt[7]  = '{1, 1, `LEFT,  0, 0, 300, 400, 1, 0};
        vt[8]  = '{1, 1, `DOWN,  0, 0, 300, 400, 1, 0};  // direction change: no step
        vt[9]  = '{1, 1, `DOWN,  0, 0, 300, 404, 1, 0};
        vt[10] = '{1, 1, `DOWN,  1, 0, 300, 404, 0, 0};  // freeze holds
        vt[11] = '{1, 1, `DOWN,  1, 0, 300, 404, 0, 0};
        vt[12] = '{1, 1, `DOWN,  1, 1, 300, 400, 0, 0};  // respawn while frozen
        vt[13] = '{1, 1, `DOWN,  0, 0, 300, 400, 1, 0};  // new press
        vt[14] = '{0, 1, `DOWN,  0, 1, 300, 400, 0, 0};  // respawn mid-press
        vt[15] = '{1, 0, `DOWN,  0, 0, 300, 400, 0, 0};

        // Reset state
        do_reset();
        check("reset_x", pos_x_o, 300);
        check("reset_y", pos_y_o, 400);
        check("reset_moving", moving_o, 0);
        check("reset_edge_hit", edge_hit_o, 0);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            cyc(vt[i].t, vt[i].en, vt[i].d, vt[i].f, vt[i].r, 0);
            check($sformatf("vec%0d_x", i), pos_x_o, vt[i].ex);
            check($sformatf("vec%0d_y", i), pos_y_o, vt[i].ey);
            check($sformatf("vec%0d_moving", i), moving_o, vt[i].em);
            check($sformatf("vec%0d_edge_hit", i), edge_hit_o, vt[i].eh);
        end

        // Hold UP for 14 ticks: steps on ticks 1, 9, 11, 13
        do_reset();
        cyc(0, 1, `UP, 0, 0, 0);
        steps_seen = 0;
        for (int k = 1; k <= 14; k++) begin
            cyc(0, 1, `UP, 0, 0, 0);
            cyc(1, 1, `UP, 0, 0, 0);
            if (k == 1 || k == 9 || k == 11 || k == 13) steps_seen++;
            ey = 400 - 4 * steps_seen;
            check($sformatf("holdup_tick%0d_y", k), pos_y_o, ey);
            check($sformatf("holdup_tick%0d_moving", k), moving_o, 1);
        end
        check("holdup_final_y", pos_y_o, 384);

        // Direction change in REPEAT from LEFT to DOWN
        do_reset();
        cyc(0, 1, `LEFT, 0, 0, 0);
        for (int k = 0; k < 10; k++) cyc(1, 1, `LEFT, 0, 0, 0);
        check("dirchg_before_x", pos_x_o, 292);
        cyc(1, 1, `DOWN, 0, 0, 0);
        check("dirchg_nostep_x", pos_x_o, 292);
        check("dirchg_nostep_y", pos_y_o, 400);
        check("dirchg_nostep_moving", moving_o, 1);
        cyc(1, 1, `DOWN, 0, 0, 0);
        check("dirchg_step_y", pos_y_o, 404);
        check("dirchg_step_x", pos_x_o, 292);

        // Right edge: reach 600 exactly, then the next step clamps (or wraps)
        do_reset();
        cyc(0, 1, `RIGHT, 0, 0, 0);
        reached = 0;
        for (int k = 0; k < 400 && !reached; k++) begin
            cyc(1, 1, `RIGHT, 0, 0, 0);
            if (pos_x_o == 10'(X_MAX)) begin
                reached = 1;
                check("edge_exact_hit", edge_hit_o, 0);
            end
        end
        check("edge_reached", reached, 1);
        stepped = 0;
        for (int k = 0; k < 20 && !stepped; k++) begin
            cyc(1, 1, `RIGHT, 0, 0, 0);
            if (edge_hit_o || pos_x_o != 10'(X_MAX)) stepped = 1;
        end
        check("edge_clamp_hit", edge_hit_o, 1);
        check("edge_clamp_x", pos_x_o, WRAP ? X_MIN : X_MAX);
        cyc(1, 1, `RIGHT, 0, 0, 0);
        check("edge_hit_pulse_end", edge_hit_o, 0);

        // Randomized run against the reference model
        do_reset();
        begin
            logic [1:0] rd;
            bit rt, ren, rf, rr, rrs;
            rd = `UP;
            for (int k = 0; k < 4000; k++) begin
                rt  = ($urandom_range(0, 1) == 0);
                ren = ($urandom_range(0, 19) != 0);
                if ($urandom_range(0, 49) == 0) rd = 2'($urandom_range(0, 3));
                rf  = ($urandom_range(0, 99) < 2);
                rr  = ($urandom_range(0, 199) == 0);
                rrs = ($urandom_range(0, 499) == 0);
                cyc(rt, ren, rd, rf, rr, rrs);
                check("rand_x", pos_x_o, mx);
                check("rand_y", pos_y_o, my);
                check("rand_moving", moving_o, mmov);
                check("rand_edge_hit", edge_hit_o, mhit);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
